// File: rtl/max_score_if.sv
// rtl/max_score_if.sv - score-beat, tree and result signals of max_score_ctrl
// MAX_SCORE_CTRL_DONE_HOLD_EN adds the i_done_ack acknowledge.
interface max_score_if #(
    parameter int DATA_WIDTH = 18,
    parameter int LANES      = 64,
    parameter int IDX_W      = 13
);
    logic                        i_start;
    logic                        i_valid;
    logic                        i_last;
    logic [LANES-1:0]            i_lane_en;
    logic [DATA_WIDTH*LANES-1:0] i_scores;
    logic                        o_ready;
    logic [DATA_WIDTH*LANES-1:0] o_tree_in;
    logic [DATA_WIDTH-1:0]       i_tree_result;
    logic                        o_busy;
    logic                        o_done;
    logic [DATA_WIDTH-1:0]       o_max;
    logic [IDX_W-1:0]            o_max_idx;
    logic [IDX_W-1:0]            o_beats;
`ifdef MAX_SCORE_CTRL_DONE_HOLD_EN
    logic                        i_done_ack;
`endif

    modport slave (
        input  i_start, i_valid, i_last, i_lane_en, i_scores, i_tree_result,
`ifdef MAX_SCORE_CTRL_DONE_HOLD_EN
        input  i_done_ack,
`endif
        output o_ready, o_tree_in, o_busy, o_done, o_max, o_max_idx, o_beats
    );

    modport master (
        output i_start, i_valid, i_last, i_lane_en, i_scores, i_tree_result,
`ifdef MAX_SCORE_CTRL_DONE_HOLD_EN
        output i_done_ack,
`endif
        input  o_ready, o_tree_in, o_busy, o_done, o_max, o_max_idx, o_beats
    );
endinterface

// File: rtl/max_score_ctrl.sv
// rtl/max_score_ctrl.sv - sequencer and running-max fold for the 64-lane max-reduction tree
// MAX_SCORE_CTRL_DONE_HOLD_EN: done holds until i_done_ack instead of pulsing one cycle.
module max_score_ctrl #(
    parameter int DATA_WIDTH = 18,
    parameter int LANES      = 64,
    parameter int TREE_LAT   = 2,
    parameter int IDX_W      = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    max_score_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      beats_q, beats_d;
    logic [TREE_LAT-1:0]   pv_q;
    logic [IDX_W-1:0]      pidx_q [TREE_LAT];

    logic                        accept;
    logic                        ready, busy, done;
    logic [DATA_WIDTH*LANES-1:0] tree_in;
    logic                        res_valid;
    logic [DATA_WIDTH-1:0]       res;
    logic                        res_wins;

    assign accept    = (state_q == RUN) && bus.i_valid;
    assign res_valid = pv_q[TREE_LAT-1];
    assign res       = bus.i_tree_result;
    // Sign-magnitude: only non-negative results with strictly larger magnitude win, so ties keep the earlier beat.
    assign res_wins  = res_valid && !res[DATA_WIDTH-1] &&
                       (res[DATA_WIDTH-2:0] > max_q[DATA_WIDTH-2:0]);

    always_comb begin
        tree_in = '0;
        for (int k = 0; k < LANES; k++) begin
            if (accept && bus.i_lane_en[k]) begin
                tree_in[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_scores[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int i = 0; i < TREE_LAT; i++) begin
                pidx_q[i] <= '0;
            end
        end else begin
            pv_q[0]   <= accept;
            pidx_q[0] <= beats_q;
            for (int i = 1; i < TREE_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        if (res_wins) begin
            max_d = res;
            idx_d = pidx_q[TREE_LAT-1];
        end

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = RUN;
                    max_d   = '0;
                    idx_d   = '0;
                    beats_d = '0;
                end
            end
            RUN: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept) begin
                    if (beats_q != {IDX_W{1'b1}}) begin
                        beats_d = beats_q + IDX_W'(1);
                    end
                    if (bus.i_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pv_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
`ifdef MAX_SCORE_CTRL_DONE_HOLD_EN
                if (bus.i_done_ack) begin
                    state_d = bus.i_start ? RUN : IDLE;
                    if (bus.i_start) begin
                        max_d   = '0;
                        idx_d   = '0;
                        beats_d = '0;
                    end
                end
`else
                state_d = bus.i_start ? RUN : IDLE;
                if (bus.i_start) begin
                    max_d   = '0;
                    idx_d   = '0;
                    beats_d = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_busy    = busy;
    assign bus.o_done    = done;
    assign bus.o_tree_in = tree_in;
    assign bus.o_max     = max_q;
    assign bus.o_max_idx = idx_q;
    assign bus.o_beats   = beats_q;
endmodule

// File: tb/tb_max_score_ctrl.sv
// tb/tb_max_score_ctrl.sv - scoreboard bench for max_score_ctrl with an OR-reduce tree model
module tb_max_score_ctrl;
    localparam int DW = 18;
    localparam int L  = 64;
    localparam int IW = 13;
    localparam int TL = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_score_if #(.DATA_WIDTH(DW), .LANES(L), .IDX_W(IW)) bus ();

    max_score_ctrl #(.DATA_WIDTH(DW), .LANES(L), .TREE_LAT(TL), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Tree model: OR of all lanes, TL cycles late; tests put one nonzero value in enabled lanes.
    logic [DW-1:0] or_all, t1, t2;
    always_comb begin
        or_all = '0;
        for (int k = 0; k < L; k++) or_all = or_all | bus.o_tree_in[k*DW +: DW];
    end
    always @(posedge clk) begin
        t1 <= or_all;
        t2 <= t1;
    end
    assign bus.i_tree_result = t2;

    typedef struct {
        logic [DW-1:0] mx;
        logic [IW-1:0] ix;
        logic [IW-1:0] bt;
        int            dc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("o_max", 32'(bus.o_max), 32'(e.mx));
                chk("o_max_idx", 32'(bus.o_max_idx), 32'(e.ix));
                chk("o_beats", 32'(bus.o_beats), 32'(e.bt));
                chk("done_latency", cyc, e.dc);
            end
        end
        done_prev <= bus.o_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] v, input logic last);
        bus.i_valid        = 1'b1;
        bus.i_last         = last;
        bus.i_lane_en      = '1;
        bus.i_scores       = '0;
        bus.i_scores[DW-1:0] = v;
        if (last) last_cyc = cyc;
        step();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic expect_run(input logic [DW-1:0] mx, input logic [IW-1:0] ix, input logic [IW-1:0] bt);
        sb.push_back('{mx, ix, bt, last_cyc + TL + 2});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.o_busy || bus.o_done) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.o_done && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_last    = 1'b0;
        bus.i_lane_en = '1;
        bus.i_scores  = '0;
`ifdef MAX_SCORE_CTRL_DONE_HOLD_EN
        bus.i_done_ack = 1'b1;
`endif
        step();
        step();
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_max", 32'(bus.o_max), 32'd0);
        chk("rst_beats", 32'(bus.o_beats), 32'd0);
        rst_n = 1'b1;
        step();

        // Three-beat run: 5, 12, 7
        do_start();
        chk("run_ready", 32'(bus.o_ready), 32'd1);
        beat(18'd5, 1'b0);
        beat(18'd12, 1'b0);
        beat(18'd7, 1'b1);
        expect_run(18'd12, 13'd1, 13'd3);
        wait_drain();
        step();
        chk("hold_max", 32'(bus.o_max), 32'd12);
        chk("hold_idx", 32'(bus.o_max_idx), 32'd1);

        // Tie and negative
        do_start();
        beat(18'd9, 1'b0);
        beat(18'd9, 1'b0);
        beat(18'h20003, 1'b1);
        expect_run(18'd9, 13'd0, 13'd3);
        wait_drain();

        // Lane masking
        do_start();
        bus.i_valid   = 1'b1;
        bus.i_last    = 1'b1;
        bus.i_lane_en = 64'h1;
        bus.i_scores  = '0;
        bus.i_scores[DW-1:0]        = 18'd4;
        bus.i_scores[63*DW +: DW]   = 18'd100;
        last_cyc = cyc;
        #1;
        chk("tree_lane0", 32'(bus.o_tree_in[DW-1:0]), 32'd4);
        chk("tree_lane63", 32'(bus.o_tree_in[63*DW +: DW]), 32'd0);
        step();
        bus.i_valid   = 1'b0;
        bus.i_last    = 1'b0;
        bus.i_lane_en = '1;
        expect_run(18'd4, 13'd0, 13'd1);
        wait_drain();

        // Start ignored in RUN, valid ignored in DRAIN
        do_start();
        bus.i_start = 1'b1;
        beat(18'd3, 1'b0);
        bus.i_start = 1'b0;
        beat(18'd8, 1'b1);
        expect_run(18'd8, 13'd1, 13'd2);
        bus.i_valid = 1'b1;
        bus.i_scores[DW-1:0] = 18'd99;
        #1;
        chk("drain_ready", 32'(bus.o_ready), 32'd0);
        chk("drain_tree_in", 32'(bus.o_tree_in[DW-1:0]), 32'd0);
        step();
        step();
        bus.i_valid = 1'b0;
        wait_drain();

`ifdef MAX_SCORE_CTRL_DONE_HOLD_EN
        bus.i_done_ack = 1'b0;
        do_start();
        beat(18'd20, 1'b1);
        expect_run(18'd20, 13'd0, 13'd1);
        wait_done();
        step();
        step();
        chk("hold_done", 32'(bus.o_done), 32'd1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("hold_start_ignored", 32'(bus.o_done), 32'd1);
        bus.i_done_ack = 1'b1;
        step();
        chk("ack_done_low", 32'(bus.o_done), 32'd0);
        chk("ack_idle", 32'(bus.o_busy), 32'd0);
`else
        do_start();
        beat(18'd20, 1'b1);
        expect_run(18'd20, 13'd0, 13'd1);
        wait_done();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("restart_busy", 32'(bus.o_busy), 32'd1);
        chk("restart_max", 32'(bus.o_max), 32'd0);
        chk("restart_beats", 32'(bus.o_beats), 32'd0);
        beat(18'd6, 1'b1);
        expect_run(18'd6, 13'd0, 13'd1);
        wait_drain();
`endif

        // Reset mid-run
        do_start();
        beat(18'd7, 1'b0);
        beat(18'd7, 1'b0);
        beat(18'd7, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_ready", 32'(bus.o_ready), 32'd0);
        chk("midrst_busy", 32'(bus.o_busy), 32'd0);
        chk("midrst_done", 32'(bus.o_done), 32'd0);
        chk("midrst_max", 32'(bus.o_max), 32'd0);
        chk("midrst_idx", 32'(bus.o_max_idx), 32'd0);
        chk("midrst_beats", 32'(bus.o_beats), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("midrst_idle", 32'(bus.o_busy), 32'd0);

        // Saturation: 8192 beats
        do_start();
        beat(18'd1, 1'b0);
        for (int i = 0; i < 8190; i++) beat(18'd0, 1'b0);
        beat(18'd50, 1'b1);
        expect_run(18'd50, 13'd8191, 13'd8191);
        wait_drain();

        if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
